// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared widths, FSM state and requester id for the two-port data-memory arbiter
package dm_arb_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester A/B handshakes plus the shared memory port
interface dm_arbiter_if import dm_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              a_req, a_we, a_gnt, a_done, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_done, b_err;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_gnt, a_done, a_rdata, a_err, b_gnt, b_done, b_rdata, b_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_gnt, a_done, a_rdata, a_err, b_gnt, b_done, b_rdata, b_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dm_arb_rr.sv
// dm_arb_rr: two-way round-robin pick; on a tie the side not granted last wins
module dm_arb_rr import dm_arb_pkg::*; (
  input  logic    a_req,
  input  logic    b_req,
  input  req_id_t last,
  output req_id_t winner
);
  assign winner = (a_req && b_req) ? ((last == REQ_A) ? REQ_B : REQ_A) : (a_req ? REQ_A : REQ_B);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: IDLE/ACCESS/RESP arbiter sharing one data memory between a CPU port (a) and a debug/DMA port (b).
// Define DM_ARB_ALIGN_CHECK_EN to reject misaligned or out-of-window addresses with err.
module dm_arbiter import dm_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic         clock,
  input logic         reset_n,
  dm_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  req_id_t           last_q, last_d, win_q, win_d, sel;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              take, cap, bad, acc, rsp;

  dm_arb_rr u_rr (.a_req(bus.a_req), .b_req(bus.b_req), .last(last_q), .winner(sel));

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign bad = (|addr_q[2:0]) | (|addr_q[ADDR_W-1:8]);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == IDLE) ? ((bus.a_req || bus.b_req) ? ACCESS : IDLE) :
              (state_q == ACCESS) ? RESP : IDLE;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      last_q    <= REQ_B;
      win_q     <= REQ_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end

  // requester fields are captured only on the IDLE->ACCESS edge, then ignored
  always_comb begin
    take      = (state_q == IDLE) && (bus.a_req || bus.b_req);
    cap       = (state_q == ACCESS) && !we_q && !bad;
    last_d    = take ? sel : last_q;
    win_d     = take ? sel : win_q;
    we_d      = take ? ((sel == REQ_A) ? bus.a_we : bus.b_we) : we_q;
    addr_d    = take ? ((sel == REQ_A) ? bus.a_addr : bus.b_addr) : addr_q;
    wdata_d   = take ? ((sel == REQ_A) ? bus.a_wdata : bus.b_wdata) : wdata_q;
    a_rdata_d = (cap && win_q == REQ_A) ? bus.mem_rdata : a_rdata_q;
    b_rdata_d = (cap && win_q == REQ_B) ? bus.mem_rdata : b_rdata_q;
  end

  always_comb begin
    acc           = (state_q == ACCESS);
    rsp           = (state_q == RESP);
    bus.a_gnt     = acc && (win_q == REQ_A);
    bus.b_gnt     = acc && (win_q == REQ_B);
    bus.a_done    = rsp && (win_q == REQ_A);
    bus.b_done    = rsp && (win_q == REQ_B);
    bus.a_err     = rsp && (win_q == REQ_A) && bad;
    bus.b_err     = rsp && (win_q == REQ_B) && bad;
    bus.mem_read  = acc && !we_q && !bad;
    bus.mem_write = acc && we_q && !bad;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.a_rdata   = a_rdata_q;
    bus.b_rdata   = b_rdata_q;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven directed vectors plus hand sequences for dropped requests and mid-access reset
module tb_dm_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nfail = 0;
  logic [63:0] mem [32];

  dm_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
  dm_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  assign bus.mem_rdata = mem[bus.mem_addr[7:3]];
  always @(posedge clock) if (bus.mem_write) mem[bus.mem_addr[7:3]] <= bus.mem_wdata;

  typedef struct {
    logic        a_req, b_req, a_we, b_we;
    logic [63:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        exp_b, exp_rd, exp_wr, exp_err;
    logic [63:0] exp_ard, exp_brd;
  } vec_t;

  localparam logic [63:0] P5 = 64'h5555555555555555;
`ifdef DM_ARB_ALIGN_CHECK_EN
  localparam logic       MIS_RD  = 1'b0;
  localparam logic       MIS_ERR = 1'b1;
  localparam logic [63:0] MIS_ARD = P5;
`else
  localparam logic       MIS_RD  = 1'b1;
  localparam logic       MIS_ERR = 1'b0;
  localparam logic [63:0] MIS_ARD = 64'h1234;
`endif

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bus.a_req = v.a_req; bus.b_req = v.b_req; bus.a_we = v.a_we; bus.b_we = v.b_we;
    bus.a_addr = v.a_addr; bus.b_addr = v.b_addr; bus.a_wdata = v.a_wdata; bus.b_wdata = v.b_wdata;
    @(negedge clock);
    chk({tag, " a_gnt"}, 64'(bus.a_gnt), 64'(!v.exp_b));
    chk({tag, " b_gnt"}, 64'(bus.b_gnt), 64'(v.exp_b));
    chk({tag, " mem_read"}, 64'(bus.mem_read), 64'(v.exp_rd));
    chk({tag, " mem_write"}, 64'(bus.mem_write), 64'(v.exp_wr));
    chk({tag, " mem_addr"}, bus.mem_addr, v.exp_b ? v.b_addr : v.a_addr);
    if (v.exp_wr) chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_b ? v.b_wdata : v.a_wdata);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    bus.a_addr = '1; bus.b_addr = '1; bus.a_we = 1'b1; bus.b_we = 1'b1;
    @(negedge clock);
    chk({tag, " a_done"}, 64'(bus.a_done), 64'(!v.exp_b));
    chk({tag, " b_done"}, 64'(bus.b_done), 64'(v.exp_b));
    chk({tag, " a_err"}, 64'(bus.a_err), 64'(!v.exp_b && v.exp_err));
    chk({tag, " b_err"}, 64'(bus.b_err), 64'(v.exp_b && v.exp_err));
    chk({tag, " strobes_resp"}, 64'({bus.mem_read, bus.mem_write, bus.a_gnt, bus.b_gnt}), 64'(0));
    chk({tag, " a_rdata"}, bus.a_rdata, v.exp_ard);
    chk({tag, " b_rdata"}, bus.b_rdata, v.exp_brd);
    @(negedge clock);
    chk({tag, " idle_done"}, 64'({bus.a_done, bus.b_done}), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 64'(i) * 64'h100;
    mem[1]  <= 64'h2;
    mem[2]  <= 64'h1234;
    mem[10] <= 64'h77;
    bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
    bus.a_addr = 0; bus.b_addr = 0; bus.a_wdata = 0; bus.b_wdata = 0;
    vt[0] = '{1,0,0,0, 64'd8,  64'd0,  64'd0, 64'd0, 0, 1,0,0, 64'h2, 64'h0};
    vt[1] = '{0,1,0,1, 64'd0,  64'd40, 64'd0, P5,    1, 0,1,0, 64'h2, 64'h0};
    vt[2] = '{1,0,0,0, 64'd40, 64'd0,  64'd0, 64'd0, 0, 1,0,0, P5,    64'h0};
    vt[3] = '{0,1,0,0, 64'd0,  64'd8,  64'd0, 64'd0, 1, 1,0,0, P5,    64'h2};
    vt[4] = '{1,1,0,0, 64'd8,  64'd40, 64'd0, 64'd0, 0, 1,0,0, 64'h2, 64'h2};
    vt[5] = '{1,1,0,0, 64'd40, 64'd40, 64'd0, 64'd0, 1, 1,0,0, 64'h2, P5};
    vt[6] = '{1,1,0,0, 64'd40, 64'd8,  64'd0, 64'd0, 0, 1,0,0, P5,    P5};
    vt[7] = '{1,0,0,0, 64'h13, 64'd0,  64'd0, 64'd0, 0, MIS_RD,0,MIS_ERR, MIS_ARD, P5};
    vt[8] = '{1,0,1,0, 64'd16, 64'd0,  64'hCAFE, 64'd0, 0, 0,1,0, MIS_ARD, P5};
    vt[9] = '{0,1,0,0, 64'd0,  64'd16, 64'd0, 64'd0, 1, 1,0,0, MIS_ARD, 64'hCAFE};

    repeat (2) @(negedge clock);
    chk("reset gnt/done/err", 64'({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.a_err, bus.b_err}), 64'(0));
    chk("reset strobes", 64'({bus.mem_read, bus.mem_write}), 64'(0));
    chk("reset mem_addr", bus.mem_addr, 64'h0);
    chk("reset mem_wdata", bus.mem_wdata, 64'h0);
    chk("reset rdata", bus.a_rdata | bus.b_rdata, 64'h0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    chk("mem@16 after write", mem[2], 64'hCAFE);

    // b raises req only while the block is busy and drops it before IDLE
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd8;
    @(negedge clock);
    bus.a_req = 0; bus.b_req = 1; bus.b_we = 0; bus.b_addr = 64'd40;
    chk("drop busy b_gnt", 64'(bus.b_gnt), 64'(0));
    @(negedge clock);
    bus.b_req = 0;
    @(negedge clock);
    repeat (2) begin
      @(negedge clock);
      chk("drop no grant", 64'({bus.a_gnt, bus.b_gnt}), 64'(0));
    end

    // reset during the ACCESS of a b write
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 64'd80; bus.b_wdata = 64'hAAAAAAAAAAAAAAAA;
    @(negedge clock);
    bus.b_req = 0;
    chk("rst b_gnt before", 64'(bus.b_gnt), 64'(1));
    chk("rst mem_write before", 64'(bus.mem_write), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("rst strobes at once", 64'({bus.mem_read, bus.mem_write, bus.b_gnt}), 64'(0));
    @(negedge clock);
    chk("rst no b_done", 64'(bus.b_done), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst no b_done later", 64'(bus.b_done), 64'(0));
    chk("rst mem@80 unchanged", mem[10], 64'h77);
    chk("rst rdata cleared", bus.a_rdata | bus.b_rdata, 64'h0);
    run_vec('{1,1,0,0, 64'd8, 64'd8, 64'd0, 64'd0, 0, 1,0,0, 64'h2, 64'h0}, "post_rst_tie");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, meaning requester and memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning data word width.
REQ-003 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_req/b_req, input, 1, access request (a = CPU port, b = debug/DMA port).
REQ-006 The block SHALL have ports a_we/b_we, input, 1, 1 = write, 0 = read.
REQ-007 The block SHALL have ports a_addr/b_addr, input, ADDR_W, byte address.
REQ-008 The block SHALL have ports a_wdata/b_wdata, input, DATA_W, write data.
REQ-009 The block SHALL have ports a_gnt/b_gnt, output, 1, one-cycle grant pulse.
REQ-010 The block SHALL have ports a_done/b_done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have ports a_rdata/b_rdata, output, DATA_W, read result.
REQ-012 The block SHALL have ports a_err/b_err, output, 1, error flag, valid with done.
REQ-013 The block SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_read (1) and mem_write (1), all outputs to the shared data memory.
REQ-014 The block SHALL have port mem_rdata, input, DATA_W, combinational read data from the memory.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any req is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 Requests SHALL be sampled only in IDLE; at the IDLE->ACCESS edge the winner's we/addr/wdata SHALL be latched, and requester inputs SHALL then be ignored until IDLE returns.
REQ-017 On a simultaneous a_req/b_req, the requester not granted last SHALL win; when only one requests, that one SHALL win.
REQ-018 The winner's gnt SHALL be high for exactly the ACCESS cycle; the requester may deassert req after seeing gnt.
REQ-019 In ACCESS, the block SHALL drive mem_addr and mem_wdata from the latches and raise exactly one of mem_read/mem_write for exactly one cycle; all other cycles SHALL have both strobes low.
REQ-020 For reads, mem_rdata SHALL be captured at the ACCESS->RESP edge into the winner's rdata; rdata SHALL hold until that requester's next read completes.
REQ-021 The winner's done SHALL be high for exactly the RESP cycle; writes SHALL leave rdata unchanged.
REQ-022 Latency: req high in cycle N (IDLE) -> gnt in N+1 -> done in N+2; peak throughput SHALL be one access per 3 cycles.
REQ-023 A req that drops before it is granted SHALL be silently discarded.
REQ-024 mem_addr SHALL be passed at full width; the memory wraps byte lanes modulo 256, and the arbiter SHALL not alter that behaviour.

Reset
REQ-025 While reset_n is low, the block SHALL force state = IDLE and drive gnt, done, err, mem_read and mem_write to 0, and rdata, mem_addr and mem_wdata to 0, with last-granted = b so that a wins the first tie.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately with no done pulse; a write that has not reached its ACCESS clock edge SHALL not occur.

Configuration
REQ-027 With DM_ARB_ALIGN_CHECK_EN defined, a request with addr[2:0] != 0 or addr[ADDR_W-1:8] != 0 SHALL still go through ACCESS with both strobes low, then pulse done with err = 1 and rdata unchanged.
REQ-028 Without DM_ARB_ALIGN_CHECK_EN, err SHALL be tied to 0 and every address SHALL be forwarded unchanged.

Structure
REQ-029 Package dm_arb_pkg SHALL hold the ADDR_W/DATA_W defaults, the state enum (IDLE, ACCESS, RESP) and the requester-id typedef (REQ_A, REQ_B).
REQ-030 Round-robin selection SHALL live in sub-module dm_arb_rr (inputs: two reqs and last-granted; output: winner id).

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Memory preloaded with 0x0000000000000002 @8; a read of addr 8 -> a_gnt at N+1, a_done at N+2, a_rdata = 0x2, b outputs idle.
- b writes 0x5555555555555555 @40, then a reads 40 -> a_rdata = 0x5555555555555555; mem_write high exactly one cycle.
- a and b both request in the same cycle, three times back to back -> grant order a, b, a, with no cycle where both gnt are high.
- reset_n pulled low during ACCESS of a b-write 0xAAAAAAAAAAAAAAAA @80 -> no b_done, mem strobes 0 at once, memory @80 unchanged.
- With DM_ARB_ALIGN_CHECK_EN, a reads addr 0x13 -> a_done with a_err = 1 and no mem_read; without the macro -> normal read, a_err = 0.
